// File: rtl/ddr_rd_pkg.sv
// ddr_rd_pkg: mosaic geometry helpers, scheduler FSM encoding and default channel bases
package ddr_rd_pkg;
    localparam int DEF_DQ_WIDTH  = 32;
    localparam int DEF_H_WIDTH   = 1280;
    localparam int DEF_H_HEIGHT  = 720;
    localparam int DEF_BURST_LEN = 8;
    function automatic int half_beats(input int h_width, input int dq_width);
        return h_width / 2 / (dq_width / 2);
    endfunction
    localparam int HB              = half_beats(DEF_H_WIDTH, DEF_DQ_WIDTH);
    localparam int BURSTS_PER_HALF = HB / DEF_BURST_LEN;
    localparam int ROW_BYTES       = DEF_H_WIDTH;
    localparam int HALF_LINES      = DEF_H_HEIGHT / 2;
    typedef enum logic [2:0] {S_IDLE, S_CALC, S_WAIT, S_ISSUE, S_DRAIN} state_t;
    localparam logic [27:0] CH_BASE [4] = '{28'h0000000, 28'h0400000, 28'h0800000, 28'h0C00000};
endpackage

// File: rtl/ddr_rd_scheduler_credit.sv
// rd_credit_tracker: line-buffer credits and outstanding-burst count gating AR issue
module rd_credit_tracker #(
    parameter int BUF_DEPTH = 64,
    parameter int BURST_LEN = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_issue,
    input  logic i_beat_free,
    input  logic i_rvalid,
    input  logic i_rlast,
    output logic o_can_issue,
    output logic o_idle
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    logic [CW-1:0] r_credits;
    logic [OW-1:0] r_outst;
    logic [CW:0]   w_cred;
    logic          w_ret;
    assign w_ret  = i_rvalid && i_rlast;
    assign w_cred = {1'b0, r_credits} + (CW+1)'(i_beat_free) - (i_issue ? (CW+1)'(BURST_LEN) : '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= CW'(BUF_DEPTH);
            r_outst   <= '0;
        end else begin
            r_credits <= w_cred > (CW+1)'(BUF_DEPTH) ? CW'(BUF_DEPTH) : w_cred[CW-1:0];
            r_outst   <= i_issue == w_ret ? r_outst : i_issue ? r_outst + OW'(1) : r_outst - OW'(r_outst != '0);
        end
    end
    assign o_can_issue = r_credits >= CW'(BURST_LEN) && r_outst < OW'(MAX_OUTST);
    assign o_idle      = r_outst == '0;
endmodule

// File: rtl/ddr_rd_scheduler.sv
// ddr_rd_scheduler: AXI read-burst sequencer fetching four camera channels in 2x2 mosaic order
module ddr_rd_scheduler
    import ddr_rd_pkg::*;
#(
    parameter int                DQ_WIDTH    = DEF_DQ_WIDTH,
    parameter int                H_WIDTH     = DEF_H_WIDTH,
    parameter int                H_HEIGHT    = DEF_H_HEIGHT,
    parameter int                ADDR_W      = 28,
    parameter int                BURST_LEN   = DEF_BURST_LEN,
    parameter int                BUF_DEPTH   = 64,
    parameter int                MAX_OUTST   = 4,
    parameter logic [ADDR_W-1:0] CH0_BASE    = ADDR_W'(CH_BASE[0]),
    parameter logic [ADDR_W-1:0] CH1_BASE    = ADDR_W'(CH_BASE[1]),
    parameter logic [ADDR_W-1:0] CH2_BASE    = ADDR_W'(CH_BASE[2]),
    parameter logic [ADDR_W-1:0] CH3_BASE    = ADDR_W'(CH_BASE[3]),
    parameter logic [ADDR_W-1:0] BANK_STRIDE = ADDR_W'(28'h0100000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [7:0]        ch_rd_bank,
    input  logic              buf_beat_free,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [7:0]        axi_arlen,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic              axi_rvalid,
    input  logic              axi_rlast,
    output logic [1:0]        channel_sel,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_overrun
);
    localparam int BPH = half_beats(H_WIDTH, DQ_WIDTH) / BURST_LEN;
    localparam int HALF = H_HEIGHT / 2;
    localparam int KW = $clog2(BPH + 1);
    localparam int RW = $clog2(H_HEIGHT + 1);
    localparam logic [ADDR_W-1:0] BASES [4] = '{CH0_BASE, CH1_BASE, CH2_BASE, CH3_BASE};
    localparam logic [ADDR_W-1:0] L_ROW_BYTES = ADDR_W'(H_WIDTH);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DQ_WIDTH);
    state_t            r_state;
    logic [7:0]        r_bank;
    logic [KW-1:0]     r_k;
    logic              r_side;
    logic [RW-1:0]     r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_ch;
    logic              r_arvalid;
    logic              r_busy;
    logic              r_done;
    logic              r_overrun;
    logic              w_lower;
    logic [1:0]        w_ch;
    logic [RW-1:0]     w_qrow;
    logic [1:0]        w_bank;
    logic [ADDR_W-1:0] w_addr;
    logic              w_k_wrap;
    logic              w_last;
    logic              w_hs;
    logic              w_can_issue;
    logic              w_idle;
    assign w_lower  = r_row >= RW'(HALF);
    assign w_ch     = {w_lower, r_side};
    assign w_qrow   = w_lower ? r_row - RW'(HALF) : r_row;
    assign w_bank   = r_bank[{w_ch, 1'b0} +: 2];
    assign w_addr   = BASES[w_ch] + ADDR_W'(w_bank) * BANK_STRIDE + ADDR_W'(w_qrow) * L_ROW_BYTES + ADDR_W'(r_k) * BURST_BYTES;
    assign w_k_wrap = r_k == KW'(BPH - 1);
    assign w_last   = w_k_wrap && r_side && r_row == RW'(H_HEIGHT - 1);
    assign w_hs     = r_arvalid && axi_arready;
    rd_credit_tracker #(
        .BUF_DEPTH(BUF_DEPTH),
        .BURST_LEN(BURST_LEN),
        .MAX_OUTST(MAX_OUTST)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .i_issue    (w_hs),
        .i_beat_free(buf_beat_free),
        .i_rvalid   (axi_rvalid),
        .i_rlast    (axi_rlast),
        .o_can_issue(w_can_issue),
        .o_idle     (w_idle)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bank    <= '0;
            r_k       <= '0;
            r_side    <= 1'b0;
            r_row     <= '0;
            r_addr    <= '0;
            r_ch      <= '0;
            r_arvalid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (frame_start && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (frame_start) begin
                    r_bank  <= ch_rd_bank;
                    r_k     <= '0;
                    r_side  <= 1'b0;
                    r_row   <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_addr  <= w_addr;
                    r_ch    <= w_ch;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (w_can_issue) begin
                    r_arvalid <= 1'b1;
                    r_state   <= S_ISSUE;
                end
                S_ISSUE: if (axi_arready) begin
                    r_arvalid <= 1'b0;
                    r_k       <= w_k_wrap ? '0 : r_k + KW'(1);
                    r_side    <= r_side ^ w_k_wrap;
                    r_row     <= r_row + RW'(w_k_wrap && r_side);
                    r_state   <= w_last ? S_DRAIN : S_CALC;
                end
                S_DRAIN: if (w_idle) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign axi_araddr    = r_addr;
    assign axi_arlen     = 8'(BURST_LEN - 1);
    assign axi_arvalid   = r_arvalid;
    assign channel_sel   = r_ch;
    assign busy          = r_busy;
    assign frame_done    = r_done;
    assign frame_overrun = r_overrun;
endmodule

// File: tb/tb_ddr_rd_scheduler.sv
// tb_ddr_rd_scheduler: scoreboard bench comparing every AR burst against a mosaic-order reference
module tb_ddr_rd_scheduler;
    typedef struct packed {
        logic [1:0]  ch;
        logic [27:0] addr;
    } ar_t;
    localparam int BASE_A [4] = '{32'h0000000, 32'h0400000, 32'h0800000, 32'h0C00000};
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [7:0]  ch_rd_bank = '0;
    logic        buf_beat_free;
    logic [27:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic        axi_arvalid;
    logic        axi_arready;
    logic        axi_rvalid;
    logic        axi_rlast;
    logic [1:0]  channel_sel;
    logic        busy;
    logic        frame_done;
    logic        frame_overrun;
    ar_t exp_q[$];
    ar_t ar_log[$];
    int  due[$];
    int  n_vec = 0, n_err = 0;
    int  ar_cnt = 0, done_cnt = 0, base = 0, cyc = 0, done_cyc = 0, last_rl_cyc = 0, last_due = 0;
    int  ar_mode = 0, bf_mode = 0, rl_mode = 0;
    int  bf_req = 0, bf_srv = 0, rl_req = 0, rl_srv = 0, nv_req = 0, nv_srv = 0;

    ddr_rd_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .ch_rd_bank   (ch_rd_bank),
        .buf_beat_free(buf_beat_free),
        .axi_araddr   (axi_araddr),
        .axi_arlen    (axi_arlen),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rvalid   (axi_rvalid),
        .axi_rlast    (axi_rlast),
        .channel_sel  (channel_sel),
        .busy         (busy),
        .frame_done   (frame_done),
        .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] bank);
        for (int n = 0; n < 7200; n++) begin
            int row, j, ch;
            logic [31:0] a;
            row = n / 10;
            j   = n % 10;
            ch  = (row >= 360 ? 2 : 0) + j / 5;
            a   = BASE_A[ch] + int'(bank[2*ch +: 2]) * 32'h0100000 + (row % 360) * 1280 + (j % 5) * 256;
            exp_q.push_back('{ch: 2'(ch), addr: a[27:0]});
        end
    endtask

    // background responder: AR acceptance, read-response returns and line-buffer drain
    initial begin
        int d;
        axi_arready   = 1'b0;
        axi_rvalid    = 1'b0;
        axi_rlast     = 1'b0;
        buf_beat_free = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                due.delete();
                last_due = 0;
            end else if (axi_arvalid && axi_arready && rl_mode != 0) begin
                d = rl_mode < 0 ? int'($urandom_range(1, 6)) : rl_mode;
                last_due = (last_due + 1 > cyc + 1 + d) ? last_due + 1 : cyc + 1 + d;
                due.push_back(last_due);
            end
            @(posedge clk);
            cyc++;
            #1;
            axi_rlast  = 1'b0;
            axi_rvalid = 1'b0;
            if (due.size() > 0 && due[0] <= cyc) begin
                void'(due.pop_front());
                axi_rlast   = 1'b1;
                axi_rvalid  = 1'b1;
                last_rl_cyc = cyc;
            end else if (rl_req > rl_srv) begin
                rl_srv++;
                axi_rlast   = 1'b1;
                axi_rvalid  = 1'b1;
                last_rl_cyc = cyc;
            end else if (nv_req > nv_srv) begin
                nv_srv++;
                axi_rlast = 1'b1;
            end else if (rl_mode < 0) begin
                axi_rvalid = $urandom_range(0, 1) == 1;
            end
            if (bf_mode == 1) buf_beat_free = 1'b1;
            else if (bf_mode == 2) buf_beat_free = $urandom_range(0, 3) != 0;
            else if (bf_req > bf_srv) begin
                bf_srv++;
                buf_beat_free = 1'b1;
            end else buf_beat_free = 1'b0;
            axi_arready = ar_mode == 1 || (ar_mode == 2 && $urandom_range(0, 2) != 0);
        end
    end

    // monitor: pops the scoreboard on every AR handshake
    initial begin
        ar_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (axi_arvalid && axi_arready) begin
                    ar_cnt++;
                    ar_log.push_back('{ch: channel_sel, addr: axi_araddr});
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL ar_extra: AR at 0x%0h with no burst expected", axi_araddr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ar_addr", axi_araddr, e.addr);
                        chk("ar_ch", channel_sel, e.ch);
                        chk("ar_len", axi_arlen, 7);
                    end
                    chk("busy_on_ar", busy, 1);
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    chk("busy_at_done", busy, 0);
                    chk("rlast_pending_at_done", due.size(), 0);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int am, input int bm, input int rm);
        @(posedge clk);
        #1;
        rst = 1'b1;
        frame_start = 1'b0;
        ar_mode = am;
        bf_mode = bm;
        rl_mode = rm;
        bf_req = bf_srv;
        rl_req = rl_srv;
        nv_req = nv_srv;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] bank, input bit expect_seq);
        @(posedge clk);
        #1;
        ch_rd_bank  = bank;
        frame_start = 1'b1;
        if (expect_seq) begin
            push_frame(bank);
            base = ar_cnt;
        end
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        ch_rd_bank  = 8'($urandom);
    endtask

    task automatic wait_ars(input string name, input int n, input int budget);
        for (int i = 0; i < budget && ar_cnt - base < n; i++) step(1);
        n_vec++;
        if (ar_cnt - base < n) begin
            n_err++;
            $display("FAIL %s: got %0d ARs, need %0d within %0d cycles", name, ar_cnt - base, n, budget);
        end
    endtask

    task automatic log_chk(input string tag, input int idx, input logic [27:0] a, input logic [1:0] c);
        if (base + idx - 1 < ar_log.size()) begin
            chk({tag, "_addr"}, ar_log[base+idx-1].addr, a);
            chk({tag, "_ch"}, ar_log[base+idx-1].ch, c);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL %s: AR #%0d never issued, required 0x%0h", tag, idx, a);
        end
    endtask

    initial begin
        int d0;
        logic [7:0]  b6;
        logic [27:0] a0;
        logic [1:0]  c0;
        do_reset(1, 1, 4);
        step(1);
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_overrun", frame_overrun, 0);
        chk("rst_araddr", axi_araddr, 0);
        chk("rst_ch", channel_sel, 0);
        chk("rst_arlen", axi_arlen, 7);
        d0 = done_cnt;
        pulse_start(8'h00, 1);
        wait_ars("t2_frame", 7200, 70000);
        log_chk("t1_ar1", 1, 28'h0000000, 2'd0);
        log_chk("t1_ar2", 2, 28'h0000100, 2'd0);
        log_chk("t1_ar6", 6, 28'h0400000, 2'd1);
        log_chk("t1_ar11", 11, 28'h0000500, 2'd0);
        log_chk("t2_ar3601", 3601, 28'h0800000, 2'd2);
        log_chk("t2_ar3606", 3606, 28'h0C00000, 2'd3);
        for (int i = 0; i < 60 && done_cnt == d0; i++) step(1);
        step(10);
        chk("t2_done_count", done_cnt - d0, 1);
        chk("t2_busy_after", busy, 0);
        chk("t2_done_after_rlast", done_cyc > last_rl_cyc, 1);
        chk("t2_exp_left", exp_q.size(), 0);
        chk("t2_ar_total", ar_cnt - base, 7200);
        do_reset(1, 1, 4);
        pulse_start(8'b11_10_01_00, 1);
        wait_ars("t3_frame", 3606, 31000);
        log_chk("t3_ar1", 1, 28'h0000000, 2'd0);
        log_chk("t3_ar6", 6, 28'h0500000, 2'd1);
        log_chk("t3_ar3601", 3601, 28'h0A00000, 2'd2);
        log_chk("t3_ar3606", 3606, 28'h0F00000, 2'd3);
        do_reset(1, 0, 1);
        pulse_start(8'($urandom), 1);
        wait_ars("t4_first8", 8, 100);
        step(40);
        chk("t4_stall_count", ar_cnt - base, 8);
        chk("t4_stall_arvalid", axi_arvalid, 0);
        bf_req += 7;
        step(30);
        chk("t4_seven_credits", ar_cnt - base, 8);
        bf_req += 1;
        wait_ars("t4_ar9", 9, 20);
        step(5);
        chk("t4_after_credit", ar_cnt - base, 9);
        do_reset(1, 1, 0);
        pulse_start(8'($urandom), 1);
        wait_ars("t5_first4", 4, 50);
        step(30);
        chk("t5_outst_stall", ar_cnt - base, 4);
        chk("t5_stall_arvalid", axi_arvalid, 0);
        rl_req++;
        wait_ars("t5_ar5", 5, 20);
        step(20);
        chk("t5_after_rlast", ar_cnt - base, 5);
        nv_req++;
        step(20);
        chk("t5_rlast_no_rvalid", ar_cnt - base, 5);
        do_reset(0, 1, 4);
        b6 = 8'($urandom);
        pulse_start(b6, 1);
        for (int i = 0; i < 20 && !axi_arvalid; i++) step(1);
        chk("t6_arvalid_up", axi_arvalid, 1);
        a0 = axi_araddr;
        c0 = channel_sel;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) pulse_start(~b6, 0);
            step(1);
            chk("t6_hold_arvalid", axi_arvalid, 1);
            chk("t6_hold_addr", axi_araddr, a0);
            chk("t6_hold_ch", channel_sel, c0);
        end
        chk("t6_overrun", frame_overrun, 1);
        chk("t6_busy", busy, 1);
        ar_mode = 1;
        wait_ars("t6_resume", 20, 300);
        chk("t6_overrun_sticky", frame_overrun, 1);
        ar_mode = 0;
        for (int i = 0; i < 40 && !axi_arvalid; i++) step(1);
        chk("t6_arvalid_again", axi_arvalid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_arvalid", axi_arvalid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_overrun", frame_overrun, 0);
        for (int r = 0; r < 2; r++) begin
            do_reset(2, 2, -1);
            pulse_start(8'($urandom), 1);
            wait_ars("t7_random", 60, 3000);
            chk("t7_no_overrun", frame_overrun, 0);
        end
        do_reset(1, 1, 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
